vec_result_writeback: RTL
=========================

Name: vec_result_writeback

Overview:
- Consumes one 16-lane ALU result pair (lo = lane bits 31:0, hi = lane bits 63:32 of each signed 64-bit lane result) and serializes it into a beat-wide register-file/memory write port.
- Sits between the vector ALU outputs and vector storage.
- Converts a single-cycle wide result into a sequence of narrow writes with backpressure.

Parameters:
- LANES, 16, number of lanes per vector.
- LANE_W, 32, bits per lane half.
- BEAT_LANES, 4, lanes per write beat; must divide LANES.
- ADDR_W, 10, write-port address width, in beat units.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  result pair presented
- in_ready  output  1  block can accept a result pair
- in_lo  input  LANES*LANE_W  low halves, lane i at [LANE_W*i +: LANE_W]
- in_hi  input  LANES*LANE_W  high halves, same packing
- in_wr_hi  input  1  1 = write lo then hi (multiply); 0 = write lo only (add)
- in_base  input  ADDR_W  beat address of first write
- mem_we  output  1  write request
- mem_ready  input  1  storage accepts write this cycle
- mem_addr  output  ADDR_W  beat address
- mem_wdata  output  BEAT_LANES*LANE_W  beat data
- done  output  1  one-cycle pulse after final beat accepted
- ovf_mask  output  LANES  per-lane overflow flags (optional feature)

Behaviour:
- Definitions: NB = LANES/BEAT_LANES (4 by default). Beat k of a half = lanes k*BEAT_LANES .. k*BEAT_LANES+BEAT_LANES-1. Lowest lane is in the lowest bits of mem_wdata.
- Reset: state IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, ovf_mask=0, beat counter=0. A reset mid-transfer abandons remaining beats; no further mem_we.
- Accept: in IDLE, in_valid & in_ready. The block registers in_lo, in_hi, in_wr_hi and in_base, and moves to WR_LO.
- in_ready is 1 only in IDLE.
- States: IDLE, WR_LO, WR_HI.
- WR_LO:
  - mem_we=1, mem_addr = base + k, mem_wdata = lo beat k.
  - k advances only on mem_we & mem_ready.
  - After beat NB-1 is accepted: go to WR_HI if wr_hi=1 (k cleared), else go to IDLE.
- WR_HI:
  - mem_addr = base + NB + k, mem_wdata = hi beat k.
  - After beat NB-1 is accepted, go to IDLE.
- Timing:
  - First mem_we is asserted the cycle after accept.
  - With mem_ready held high, a transfer takes NB beats (lo only) or 2*NB beats (lo and hi), one per cycle.
- Outputs during stall: mem_addr, mem_wdata and mem_we hold stable while mem_ready=0.
- done: registered. It is 1 in the first IDLE cycle after the final beat is accepted, else 0.
- Back-to-back: in_ready is 1 in that same cycle, so a new accept may coincide with done=1. No bubble beyond that IDLE cycle.
- Address arithmetic: modulo 2^ADDR_W. Example: base = 2^ADDR_W-2 wraps to 0 mid-transfer.
- in_valid in non-IDLE states is ignored; the source must hold it.
- Input data is captured at accept; later input changes do not affect the transfer.

Optional Feature:
- Macro: VWB_OVF_FLAG_EN.
- Defined:
  - At accept, ovf_mask[i] is registered as 1 when hi lane i != {LANE_W{lo lane i bit LANE_W-1}}, i.e. the 64-bit result does not fit in signed LANE_W bits.
  - The flag is computed regardless of in_wr_hi.
  - ovf_mask holds until the next accept.
- Undefined: ovf_mask is constant 0 and no comparison logic is built.

Test Plan:
- Add writeback:
  - Stimulus: in_wr_hi=0, base=0x010, lo lane i = i+1, mem_ready=1.
  - Response: 4 beats at 0x010..0x013.
  - Beat 0 data = {4,3,2,1}.
  - done pulses the cycle after the 4th beat; no hi writes.
- Multiply writeback:
  - Stimulus: in_wr_hi=1, base=0x020, lo lane i = 0x1000_0000+i, hi lane i = i.
  - Response: 8 beats at 0x020..0x027; hi beat 0 at 0x024 = {3,2,1,0}.
- Backpressure:
  - Stimulus: mem_ready low for 3 cycles on beat 2.
  - Response: mem_addr and mem_wdata stay at beat 2 throughout the stall; total beat count unchanged; done pulses exactly once.
- Wrap and back-to-back:
  - Stimulus: base=0x3FE, wr_hi=1; a second request is pending.
  - Response: first transfer's addresses are 0x3FE, 0x3FF, 0x000..0x005; the second request is accepted in the done cycle.
- Reset mid-transfer:
  - Stimulus: rst=1 during WR_HI beat 1.
  - Response: next cycle mem_we=0, in_ready=1, done=0; no further writes.
- Overflow flag (VWB_OVF_FLAG_EN):
  - Stimulus: lane 0 lo=0xFFFF_FFFF, hi=0xFFFF_FFFF; lane 1 lo=0x8000_0000, hi=0.
  - Response: ovf_mask[0]=0, ovf_mask[1]=1.
  - With the macro undefined, ovf_mask = 0.

Source files
------------

// File: rtl/vec_result_writeback_if.sv
// Bus interfaces for vec_result_writeback.
//   vwb_in_if  : result-pair handshake from the vector ALU.
//                master = producer (drives in_valid/in_lo/in_hi/in_wr_hi/in_base),
//                slave  = writeback block (drives in_ready).
//   vwb_mem_if : beat-wide write port toward vector storage.
//                master = writeback block (drives mem_we/mem_addr/mem_wdata),
//                slave  = storage (drives mem_ready).

interface vwb_in_if #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned LANE_W = 32,
  parameter int unsigned ADDR_W = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*LANE_W-1:0] in_lo;
  logic [LANES*LANE_W-1:0] in_hi;
  logic                    in_wr_hi;
  logic [ADDR_W-1:0]       in_base;

  modport master (output in_valid, in_lo, in_hi, in_wr_hi, in_base, input in_ready);
  modport slave  (input in_valid, in_lo, in_hi, in_wr_hi, in_base, output in_ready);
endinterface

interface vwb_mem_if #(
  parameter int unsigned BEAT_LANES = 4,
  parameter int unsigned LANE_W     = 32,
  parameter int unsigned ADDR_W     = 10
);
  logic                         mem_we;
  logic                         mem_ready;
  logic [ADDR_W-1:0]            mem_addr;
  logic [BEAT_LANES*LANE_W-1:0] mem_wdata;

  modport master (output mem_we, mem_addr, mem_wdata, input mem_ready);
  modport slave  (input mem_we, mem_addr, mem_wdata, output mem_ready);
endinterface

// File: rtl/vec_result_writeback.sv
// vec_result_writeback: captures one 16-lane result pair (lo/hi halves) and
// serializes it into beat-wide writes toward vector storage with backpressure.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   in_port    : vwb_in_if.slave  - result pair handshake (in_ready only in IDLE)
//   mem_port   : vwb_mem_if.master - write beats; held stable while mem_ready=0
//   done       : one-cycle pulse in the first IDLE cycle after the final beat
//   ovf_mask   : per-lane "64-bit result does not fit in LANE_W signed bits"
// Optional feature macro: VWB_OVF_FLAG_EN (ovf_mask tied to 0 when undefined).

module vec_result_writeback #(
  parameter int unsigned LANES      = 16,
  parameter int unsigned LANE_W     = 32,
  parameter int unsigned BEAT_LANES = 4,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  vwb_in_if.slave          in_port,
  vwb_mem_if.master        mem_port,
  output logic             done,
  output logic [LANES-1:0] ovf_mask
);

  localparam int unsigned NB     = LANES / BEAT_LANES;
  localparam int unsigned VEC_W  = LANES * LANE_W;
  localparam int unsigned BEAT_W = BEAT_LANES * LANE_W;
  localparam int unsigned KW     = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WR_LO = 2'd1;
  localparam logic [1:0] WR_HI = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic              wr_hi_q, wr_hi_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [VEC_W-1:0]  lo_q, lo_d;
  logic [VEC_W-1:0]  hi_q, hi_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BEAT_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              accept_c;
  logic              last_c;
  logic              beat_ok_c;
`ifdef VWB_OVF_FLAG_EN
  logic [LANES-1:0]  ovf_q, ovf_d;
`endif

  // Next-state and next-output logic; outputs are computed from the next
  // state so every port is driven straight from a flop.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wr_hi_d     = wr_hi_q;
    base_d      = base_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    done_d      = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    accept_c    = 1'b0;
    last_c      = (k_q == KW'(NB - 1));
    beat_ok_c   = mem_we_q & mem_port.mem_ready;
`ifdef VWB_OVF_FLAG_EN
    ovf_d       = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_port.in_valid && in_ready_q) begin
          accept_c = 1'b1;
          state_d  = WR_LO;
          k_d      = '0;
        end
      end
      WR_LO: begin
        if (beat_ok_c) begin
          if (last_c) begin
            k_d = '0;
            if (wr_hi_q) begin
              state_d = WR_HI;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      WR_HI: begin
        if (beat_ok_c) begin
          if (last_c) begin
            k_d     = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase

    // Capture the whole request at accept; later input changes are ignored.
    if (accept_c) begin
      wr_hi_d = in_port.in_wr_hi;
      base_d  = in_port.in_base;
      lo_d    = in_port.in_lo;
      hi_d    = in_port.in_hi;
`ifdef VWB_OVF_FLAG_EN
      // Lane overflows when hi is not the sign extension of lo.
      for (int i = 0; i < int'(LANES); i++) begin
        ovf_d[i] = (in_port.in_hi[LANE_W*i +: LANE_W] !=
                    {LANE_W{in_port.in_lo[LANE_W*i + LANE_W - 1]}});
      end
`endif
    end

    // Present the beat for the next cycle; hi beats sit NB above the lo beats.
    if (state_d == WR_LO) begin
      mem_addr_d  = base_d + ADDR_W'(k_d);
      mem_wdata_d = lo_d[BEAT_W*k_d +: BEAT_W];
    end else if (state_d == WR_HI) begin
      mem_addr_d  = base_d + ADDR_W'(NB) + ADDR_W'(k_d);
      mem_wdata_d = hi_d[BEAT_W*k_d +: BEAT_W];
    end

    mem_we_d   = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      wr_hi_q     <= 1'b0;
      base_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
`ifdef VWB_OVF_FLAG_EN
      ovf_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wr_hi_q     <= wr_hi_d;
      base_q      <= base_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
`ifdef VWB_OVF_FLAG_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_port.in_ready   = in_ready_q;
  assign mem_port.mem_we    = mem_we_q;
  assign mem_port.mem_addr  = mem_addr_q;
  assign mem_port.mem_wdata = mem_wdata_q;
  assign done               = done_q;
`ifdef VWB_OVF_FLAG_EN
  assign ovf_mask           = ovf_q;
`else
  assign ovf_mask           = '0;
`endif

endmodule
